// File: rtl/chaos_seq_gen.sv
// rtl/chaos_seq_gen.sv - fixed-point logistic-map chaotic tuple generator
// Define CHAOS_PERTURB_EN to XOR a 16-bit LFSR into the low byte of every new map state.
module chaos_seq_gen #(
   parameter int          CHAOS_OVLD_W = 32,
   parameter logic [31:0] R_Q          = 32'h7FAE147B,
   parameter int          BURN_IN      = 64,
   parameter logic [31:0] DEFAULT_SEED = 32'h5A5A_5A5A
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             seed,
   input  logic                    seed_load,
   input  logic                    en,
   output logic [CHAOS_OVLD_W-1:0] rand_x1,
   output logic [CHAOS_OVLD_W-1:0] rand_x2,
   output logic [CHAOS_OVLD_W-1:0] rand_x3,
   output logic [CHAOS_OVLD_W-1:0] rand_z1,
   output logic [CHAOS_OVLD_W-1:0] rand_z2,
   output logic                    rand_vld,
   input  logic                    rand_rdy,
   output logic                    busy
);

   typedef enum logic [1:0] {S_IDLE, S_BURN, S_GEN, S_OUT} state_t;

   localparam logic [9:0] BURN_LAST = (BURN_IN == 0) ? 10'd0 : 10'(BURN_IN - 1);
   localparam state_t     START_ST  = (BURN_IN == 0) ? S_GEN : S_BURN;

   state_t      state, state_nxt;
   logic        phase;
   logic [9:0]  cnt;
   logic [31:0] x, q;
   logic [31:0] sh_x1, sh_x2, sh_x3, sh_z1;
   logic [31:0] mul_a, mul_b;
   logic [63:0] prod;
   logic [31:0] x_mul, x_raw, x_next, seed_val;
   logic        step, iter_done, burn_done, gen_done;

   // Phase A forms x*(1-x) (~x is 2^32-1-x); phase B scales the stored q by r.
   always_comb begin
      mul_a = phase ? q : x;
      mul_b = phase ? R_Q : ~x;
      prod  = {32'd0, mul_a} * {32'd0, mul_b};
   end

   assign x_mul = 32'(prod >> 29);

`ifdef CHAOS_PERTURB_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (!rst_n || seed_load) begin
         lfsr <= 16'hACE1;
      end else if (iter_done) begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign x_raw = x_mul ^ {24'd0, lfsr[7:0]};
`else
   assign x_raw = x_mul;
`endif

   // Zero is an absorbing point of the map, so it is never allowed into x.
   assign x_next   = (x_raw == 32'd0) ? DEFAULT_SEED : x_raw;
   assign seed_val = (seed == 32'd0) ? DEFAULT_SEED : seed;

   assign busy      = (state == S_BURN) || (state == S_GEN);
   assign rand_vld  = (state == S_OUT);
   assign step      = en && busy;
   assign iter_done = step && phase;
   assign burn_done = iter_done && (state == S_BURN) && (cnt == BURN_LAST);
   assign gen_done  = iter_done && (state == S_GEN) && (cnt == 10'd4);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (en) state_nxt = START_ST;
         S_BURN:  if (burn_done) state_nxt = S_GEN;
         S_GEN:   if (gen_done) state_nxt = S_OUT;
         S_OUT:   if (rand_rdy) state_nxt = S_GEN;
         default: state_nxt = S_IDLE;
      endcase
      if (seed_load) state_nxt = START_ST;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         phase   <= 1'b0;
         cnt     <= 10'd0;
         x       <= DEFAULT_SEED;
         q       <= 32'd0;
         sh_x1   <= 32'd0;
         sh_x2   <= 32'd0;
         sh_x3   <= 32'd0;
         sh_z1   <= 32'd0;
         rand_x1 <= '0;
         rand_x2 <= '0;
         rand_x3 <= '0;
         rand_z1 <= '0;
         rand_z2 <= '0;
      end else begin
         state <= state_nxt;
         if (seed_load) begin
            x     <= seed_val;
            phase <= 1'b0;
            cnt   <= 10'd0;
         end else if (step) begin
            phase <= ~phase;
            if (!phase) begin
               q <= 32'(prod >> 32);
            end else begin
               x   <= x_next;
               cnt <= (burn_done || gen_done) ? 10'd0 : cnt + 10'd1;
               if (state == S_GEN) begin
                  case (cnt[2:0])
                     3'd0:    sh_x1 <= x_next;
                     3'd1:    sh_x2 <= x_next;
                     3'd2:    sh_x3 <= x_next;
                     3'd3:    sh_z1 <= x_next;
                     default: ;
                  endcase
               end
               // The fifth result goes straight to rand_z2 as the tuple is published.
               if (gen_done) begin
                  rand_x1 <= sh_x1;
                  rand_x2 <= sh_x2;
                  rand_x3 <= sh_x3;
                  rand_z1 <= sh_z1;
                  rand_z2 <= x_next;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_chaos_seq_gen.sv
// tb/tb_chaos_seq_gen.sv - scoreboard bench for chaos_seq_gen (default and zero burn-in)
module tb_chaos_seq_gen;

   localparam logic [31:0] R_COEF = 32'h7FAE147B;
   localparam logic [31:0] DSEED  = 32'h5A5A_5A5A;

   logic        clk = 1'b0;
   logic        rst_n, en_d, en_z, rdy_d, rdy_z, seed_ld_d, seed_ld_z;
   logic [31:0] seed;
   logic [31:0] d_x1, d_x2, d_x3, d_z1, d_z2, z_x1, z_x2, z_x3, z_z1, z_z2;
   logic        vld_d, vld_z, busy_d, busy_z;
   logic [159:0] obs_d, obs_z, cur_z;
   logic [159:0] q_d[$];
   logic [159:0] q_z[$];
   logic [31:0]  mx_d, mx_z;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign obs_d = {d_x1, d_x2, d_x3, d_z1, d_z2};
   assign obs_z = {z_x1, z_x2, z_x3, z_z1, z_z2};

   chaos_seq_gen u_dut_d (
      .clk(clk), .rst_n(rst_n), .seed(seed), .seed_load(seed_ld_d), .en(en_d),
      .rand_x1(d_x1), .rand_x2(d_x2), .rand_x3(d_x3), .rand_z1(d_z1), .rand_z2(d_z2),
      .rand_vld(vld_d), .rand_rdy(rdy_d), .busy(busy_d)
   );

   chaos_seq_gen #(.BURN_IN(0)) u_dut_z (
      .clk(clk), .rst_n(rst_n), .seed(seed), .seed_load(seed_ld_z), .en(en_z),
      .rand_x1(z_x1), .rand_x2(z_x2), .rand_x3(z_x3), .rand_z1(z_z1), .rand_z2(z_z2),
      .rand_vld(vld_z), .rand_rdy(rdy_z), .busy(busy_z)
   );

   function automatic logic [31:0] mstep(input logic [31:0] xv);
      logic [31:0] nx, qv;
      logic [63:0] p;
      nx = ~xv;
      p  = {32'd0, xv} * {32'd0, nx};
      qv = p[63:32];
      p  = {32'd0, qv} * {32'd0, R_COEF};
      qv = p[60:29];
      return (qv == 32'd0) ? DSEED : qv;
   endfunction

   function automatic logic [159:0] mtuple(input logic [31:0] xv);
      logic [159:0] t;
      logic [31:0]  xs;
      t  = '0;
      xs = xv;
      for (int i = 0; i < 5; i++) begin
         xs = mstep(xs);
         t  = {t[127:0], xs};
      end
      return t;
   endfunction

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sb_seed(input bit sel, input logic [31:0] s, input int burn);
      logic [31:0]  xs;
      logic [159:0] t;
      xs = (s == 32'd0) ? DSEED : s;
      for (int i = 0; i < burn; i++) xs = mstep(xs);
      t = mtuple(xs);
      if (sel) begin
         q_z.delete(); q_z.push_back(t); mx_z = t[31:0];
      end else begin
         q_d.delete(); q_d.push_back(t); mx_d = t[31:0];
      end
   endtask

   task automatic sb_next(input bit sel);
      logic [159:0] t;
      if (sel) begin
         t = mtuple(mx_z); mx_z = t[31:0]; q_z.push_back(t);
      end else begin
         t = mtuple(mx_d); mx_d = t[31:0]; q_d.push_back(t);
      end
   endtask

   // Reference edge is the first rising edge after the call; lat counts edges after it.
   task automatic wait_vld(input bit sel, input int lat, input string tag);
      int n;
      logic v;
      logic [159:0] t;
      n = 0;
      do begin
         @(negedge clk);
         seed_ld_d = 1'b0;
         seed_ld_z = 1'b0;
         if (sel) rdy_z = 1'b0;
         n++;
         v = sel ? vld_z : vld_d;
      end while (!v && n < 400);
      chk({tag, "_latency"}, 192'(n - 1), 192'(lat));
      t = 'x;
      if (sel && q_z.size() > 0) t = q_z.pop_front();
      if (!sel && q_d.size() > 0) t = q_d.pop_front();
      chk({tag, "_tuple"}, 192'(sel ? obs_z : obs_d), 192'(t));
      if (sel) cur_z = t;
   endtask

   initial begin
      rst_n = 1'b0; en_d = 1'b0; en_z = 1'b0; rdy_d = 1'b0; rdy_z = 1'b0;
      seed_ld_d = 1'b0; seed_ld_z = 1'b0; seed = 32'd0; cur_z = '0;
      mx_d = DSEED; mx_z = DSEED;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_d", 192'({obs_d, vld_d, busy_d}), 192'd0);
         chk("idle_z", 192'({obs_z, vld_z, busy_z}), 192'd0);
      end

      // Zero burn-in: known first value from seed 0x8000_0000.
      seed = 32'h8000_0000; seed_ld_z = 1'b1; en_z = 1'b1; sb_seed(1'b1, seed, 0);
      wait_vld(1'b1, 10, "b0_seed80");
      chk("b0_x1_const", 192'(z_x1), 192'(32'hFF5C_28F2));
      chk("b0_busy_out", 192'(busy_z), 192'd0);

      // Backpressure: data and valid hold, then one transfer.
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("hold_z", 192'({vld_z, obs_z}), 192'({1'b1, cur_z}));
      end
      rdy_z = 1'b1; sb_next(1'b1);
      wait_vld(1'b1, 10, "bp_release");

      // Zero seed behaves as the default seed.
      seed = 32'd0; seed_ld_z = 1'b1; sb_seed(1'b1, 32'd0, 0);
      wait_vld(1'b1, 10, "seed_zero");
      chk("seed_zero_eq_def", 192'(cur_z), 192'(mtuple(DSEED)));
      seed = DSEED; seed_ld_z = 1'b1; sb_seed(1'b1, DSEED, 0);
      wait_vld(1'b1, 10, "seed_def");

      // Handshake and seed_load on the same edge.
      rdy_z = 1'b1; seed = 32'h1357_9BDF; seed_ld_z = 1'b1; sb_seed(1'b1, seed, 0);
      wait_vld(1'b1, 10, "hs_load");

      // seed_load in the middle of GEN.
      rdy_z = 1'b1;
      @(negedge clk);
      rdy_z = 1'b0;
      repeat (3) @(negedge clk);
      chk("midgen_busy", 192'({busy_z, vld_z}), 192'(2'b10));
      seed = 32'h0F0F_1234; seed_ld_z = 1'b1; sb_seed(1'b1, seed, 0);
      wait_vld(1'b1, 10, "midgen_load");

      // Default parameters: 138-cycle start, 11-cycle tuple spacing, 100 tuples.
      rdy_d = 1'b1; en_d = 1'b1; seed = 32'h3C3C_0001; seed_ld_d = 1'b1;
      sb_seed(1'b0, seed, 64);
      wait_vld(1'b0, 138, "def_first");
      for (int i = 1; i < 100; i++) begin
         sb_next(1'b0);
         wait_vld(1'b0, 10, "def_stream");
      end

      // Reset in the middle of BURN.
      seed = 32'h2468_ACE0; seed_ld_d = 1'b1;
      @(negedge clk);
      seed_ld_d = 1'b0;
      repeat (19) @(negedge clk);
      chk("burn_busy", 192'({busy_d, vld_d}), 192'(2'b10));
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_burn_d", 192'({obs_d, vld_d, busy_d}), 192'd0);
      chk("rst_mid_burn_z", 192'({obs_z, vld_z, busy_z}), 192'd0);
      rst_n = 1'b1; sb_seed(1'b0, DSEED, 64);
      wait_vld(1'b0, 138, "post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/chaos_seq_gen.md
# chaos_seq_gen

Fixed-point logistic-map chaotic sequence generator feeding the sparse-matrix builder (`mat_csc`). Produces five 32-bit chaotic variables (x1, x2, x3, z1, z2) per tuple through a valid/ready handshake. The variables are consumed as Q0.32 fractions whose upper 16 bits give the 0–1 range downstream. It iterates one shared map with a single time-shared 32×32 multiplier, discards a burn-in transient after every seed load, and holds each tuple until it is accepted.

## Interface
Parameters:
- `CHAOS_OVLD_W`, default 32: output width. Only 32 is supported.
- `R_Q`, default 32'h7FAE147B: map coefficient r in Q3.29 (3.99). Must be below 4.0.
- `BURN_IN`, default 64: iterations discarded after a seed load. Legal range 0..1023.
- `DEFAULT_SEED`, default 32'h5A5A_5A5A: reset state and replacement for a zero seed.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `seed` in 32: new map state in Q0.32.
- `seed_load` in 1: one-cycle strobe that loads `seed` and restarts the sequence.
- `en` in 1: run enable. Gates the iteration phases only.
- `rand_x1`, `rand_x2`, `rand_x3`, `rand_z1`, `rand_z2` out 32 each: tuple outputs, registered.
- `rand_vld` out 1: tuple valid.
- `rand_rdy` in 1: consumer ready.
- `busy` out 1: high in BURN or GEN.

## Operation
- State x is 32 bits in Q0.32, with value x/2^32.
- One iteration takes two cycles and uses the same 64-bit multiplier in both:
  - Phase A: q = (x · (2^32−1−x)) >> 32. q ≤ 0x3FFF_FFFF.
  - Phase B: x' = (q · R_Q) >> 29, taking product bits [60:29]. No overflow is possible, since r < 4.
  - All shifts truncate (floor). No rounding.
- Zero trap: if x' == 0, load DEFAULT_SEED instead. If `seed` == 0 on load, load DEFAULT_SEED.
- FSM states and transitions:
  - IDLE → BURN on `en`.
  - BURN: runs BURN_IN iterations, with results discarded. → GEN. If BURN_IN = 0, go straight to GEN.
  - GEN: runs 5 iterations, written in order to x1, x2, x3, z1, z2 shadow registers. → OUT.
  - OUT: `rand_vld` = 1 and outputs hold stable. On `rand_vld & rand_rdy` → GEN.
- `en` = 0 in BURN or GEN freezes phase, counter and x. OUT and IDLE are unaffected.
- `seed_load` is accepted in any state:
  - x is loaded with `seed` (zero replaced).
  - The iteration counter clears.
  - The next state is BURN; `en` is ignored for this transition.
  - `rand_vld` drops on the same edge.
- `seed_load` together with a handshake: the tuple counts as transferred, and `seed_load` wins the next-state choice.
- `rst_n` low at any time, including mid-iteration:
  - state = IDLE, x = DEFAULT_SEED.
  - All outputs are 0, `rand_vld` = 0, `busy` = 0.

## Timing
- Reset values: all `rand_*` data = 0, `rand_vld` = 0, `busy` = 0.
- Tuple registers update only on the edge entering OUT. Data is stable for the whole time `rand_vld` = 1.
- Latency from the `seed_load` edge t0 (with `en` = 1): `rand_vld` rises at edge t0 + 2·BURN_IN + 10. With defaults this is t0 + 138.
- Handshake at edge t: `rand_vld` is low from t, and rises again at t + 10.
- Peak throughput: one tuple per 11 cycles.
- `rand_vld` never depends combinationally on `rand_rdy`.
- `rand_vld`, once high, stays high until a handshake, `seed_load` or reset.

## Configuration
- `CHAOS_PERTURB_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; seed 16'hACE1 on reset and on `seed_load`) advances once per iteration.
  - Its low 8 bits are XORed into x'[7:0] before the zero trap.
  - This breaks fixed-point short cycles.
- `CHAOS_PERTURB_EN` undefined: no LFSR. The map is bit-exact as described under Operation.
- The Test plan values below apply with the macro undefined.

## Test plan
- Reset held for 3 cycles, then released with `en` = 0: all outputs 0, `rand_vld` = 0, `busy` = 0, state stays IDLE for 20 cycles.
- BURN_IN = 0, `seed_load` with `seed` = 32'h8000_0000 and `en` = 1: `rand_vld` rises 10 cycles later, with `rand_x1` = 32'hFF5C_28F2. x2..z2 match a golden model.
- Defaults, `seed_load` at t0 with `rand_rdy` = 1: `rand_vld` first rises at t0 + 138. Successive tuples arrive 11 cycles apart. 100 tuples are bit-exact against the model.
- Backpressure: `rand_rdy` = 0 for 50 cycles while `rand_vld` = 1. All five outputs stay unchanged. `rdy` = 1 then completes one transfer, and `rand_vld` is low for exactly 10 cycles.
- `seed` = 0 with BURN_IN = 0: the tuple equals the one produced by `seed` = DEFAULT_SEED.
- `seed_load` mid-GEN, in the same cycle as a handshake, and `rst_n` low mid-BURN: restart latency is t + 2·BURN_IN + 10, no stale tuple is emitted, and reset values apply on the next edge.
